// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, flush and optional
// 2-entry skid buffer (SKID=1) that keeps out_ready off the in_ready path.
module exe_mem_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_st_val,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_val;
    logic [DEST_W-1:0] dest;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t h_q, h_d;
  entry_t s_q, s_d;
  entry_t in_e;
  logic   accept;
  logic   pop;

  function automatic entry_t clr_ctl(input entry_t e);
    entry_t r;
    r          = e;
    r.wb_en    = 1'b0;
    r.mem_r_en = 1'b0;
    r.mem_w_en = 1'b0;
    return r;
  endfunction

  assign out_valid = (state_q != EMPTY);

  // SKID=1 derives in_ready only from the state register, never from out_ready
  always_comb begin
    if (SKID != 0) in_ready = ~flush & (state_q != FULL);
    else           in_ready = ~flush & (out_ready | ~out_valid);
  end

  always_comb begin
    in_e    = '{in_pc, in_alu_result, in_st_val, in_dest,
                in_wb_en, in_mem_r_en, in_mem_w_en};
    accept  = in_valid & in_ready;
    pop     = out_valid & out_ready;
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
      h_d     = clr_ctl(h_q);
      s_d     = clr_ctl(s_q);
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            h_d     = in_e;
          end
        end
        ONE: begin
          if (accept && pop) begin
            h_d = in_e;
          end else if (accept && (SKID != 0)) begin
            state_d = FULL;
            s_d     = in_e;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            h_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      h_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    unique case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_pc         = h_q.pc;
  assign out_alu_result = h_q.alu_result;
  assign out_st_val     = h_q.st_val;
  assign out_dest       = h_q.dest;
  assign out_wb_en      = out_valid & h_q.wb_en;
  assign out_mem_r_en   = out_valid & h_q.mem_r_en;
  assign out_mem_w_en   = out_valid & h_q.mem_w_en;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Scoreboard bench for exe_mem_pipe_reg: one SKID=1 and one SKID=0 instance
// share data inputs; each has its own valid/ready and its own expected queue.
module tb_exe_mem_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] in_valid;
  logic [1:0] out_ready;
  ent_t       stim;

  logic        ir1, o1_valid, o1_wb, o1_mr, o1_mw;
  logic [31:0] o1_pc, o1_alu, o1_st;
  logic [4:0]  o1_dest;
  logic [1:0]  o1_occ;
  logic        ir0, o0_valid, o0_wb, o0_mr, o0_mw;
  logic [31:0] o0_pc, o0_alu, o0_st;
  logic [4:0]  o0_dest;
  logic [1:0]  o0_occ;

  int n_checks = 0;
  int n_fail   = 0;
  ent_t q1[$];
  ent_t q0[$];

  always #5 clk = ~clk;

  exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(5), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(ir1),
    .in_pc(stim.pc), .in_alu_result(stim.alu), .in_st_val(stim.st),
    .in_dest(stim.dest), .in_wb_en(stim.wb), .in_mem_r_en(stim.mr),
    .in_mem_w_en(stim.mw),
    .out_valid(o1_valid), .out_ready(out_ready[1]),
    .out_pc(o1_pc), .out_alu_result(o1_alu), .out_st_val(o1_st),
    .out_dest(o1_dest), .out_wb_en(o1_wb), .out_mem_r_en(o1_mr),
    .out_mem_w_en(o1_mw), .occupancy(o1_occ)
  );

  exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(5), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(ir0),
    .in_pc(stim.pc), .in_alu_result(stim.alu), .in_st_val(stim.st),
    .in_dest(stim.dest), .in_wb_en(stim.wb), .in_mem_r_en(stim.mr),
    .in_mem_w_en(stim.mw),
    .out_valid(o0_valid), .out_ready(out_ready[0]),
    .out_pc(o0_pc), .out_alu_result(o0_alu), .out_st_val(o0_st),
    .out_dest(o0_dest), .out_wb_en(o0_wb), .out_mem_r_en(o0_mr),
    .out_mem_w_en(o0_mw), .occupancy(o0_occ)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_pop(input string name, input ent_t act, inout ent_t q[$]);
    ent_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected output pc=0x%0h, expected none", name, act.pc);
    end else begin
      e = q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got pc=%h alu=%h st=%h dest=%0d ctl=%b%b%b, expected pc=%h alu=%h st=%h dest=%0d ctl=%b%b%b",
                 name, act.pc, act.alu, act.st, act.dest, act.wb, act.mr, act.mw,
                 e.pc, e.alu, e.st, e.dest, e.wb, e.mr, e.mw);
      end
    end
  endtask

  // Monitor: sample mid-cycle; pop-compare first, then flush/reset clears, then record accepts
  always @(negedge clk) begin
    ent_t a1, a0;
    a1 = '{o1_pc, o1_alu, o1_st, o1_dest, o1_wb, o1_mr, o1_mw};
    a0 = '{o0_pc, o0_alu, o0_st, o0_dest, o0_wb, o0_mr, o0_mw};
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      chk("d1 occ bound", 64'(o1_occ > 2'd2), 64'd0);
      chk("d0 occ bound", 64'(o0_occ > 2'd1), 64'd0);
      if (!o1_valid) chk("d1 bubble ctl", {o1_wb, o1_mr, o1_mw}, 64'd0);
      if (!o0_valid) chk("d0 bubble ctl", {o0_wb, o0_mr, o0_mw}, 64'd0);
      if (o1_valid && out_ready[1]) cmp_pop("d1 data", a1, q1);
      if (o0_valid && out_ready[0]) cmp_pop("d0 data", a0, q0);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (in_valid[1] && ir1) q1.push_back(stim);
        if (in_valid[0] && ir0) q0.push_back(stim);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] st, input logic [4:0] dest,
                              input logic wb, input logic mr, input logic mw);
    return '{pc, alu, st, dest, wb, mr, mw};
  endfunction

  initial begin
    // Reset held 2 cycles with input offered
    rst = 1'b1; flush = 1'b0; in_valid = 2'b11; out_ready = 2'b00;
    stim = mk(32'hA5A5_0000, 32'h1234, 32'h5678, 5'd31, 1'b1, 1'b1, 1'b1);
    step(); step();
    rst = 1'b0; in_valid = 2'b00; #1;
    chk("rst d1 valid", o1_valid, 0);
    chk("rst d1 occ", o1_occ, 0);
    chk("rst d1 in_ready", ir1, 1);
    chk("rst d1 pc/alu", {o1_pc, o1_alu}, 64'd0);
    chk("rst d1 st/dest/ctl", {o1_st, o1_dest, o1_wb, o1_mr, o1_mw}, 64'd0);
    chk("rst d0 valid", o0_valid, 0);
    chk("rst d0 occ", o0_occ, 0);
    chk("rst d0 in_ready", ir0, 1);
    chk("rst d0 pc", o0_pc, 0);

    // Back-to-back stream through SKID=1
    out_ready = 2'b10; in_valid[1] = 1'b1;
    stim = mk(32'h100, 32'h1, 32'h10, 5'd1, 1'b1, 1'b0, 1'b0); step();
    chk("stream pc0", o1_pc, 32'h100); chk("stream occ0", o1_occ, 1);
    stim = mk(32'h104, 32'h2, 32'h20, 5'd2, 1'b1, 1'b0, 1'b0); step();
    chk("stream pc1", o1_pc, 32'h104); chk("stream occ1", o1_occ, 1);
    stim = mk(32'h108, 32'h3, 32'h30, 5'd3, 1'b0, 1'b1, 1'b0); step();
    chk("stream pc2", o1_pc, 32'h108); chk("stream occ2", o1_occ, 1);
    chk("stream in_ready", ir1, 1);
    in_valid[1] = 1'b0; step();
    chk("stream drained valid", o1_valid, 0); chk("stream drained occ", o1_occ, 0);

    // Fill skid buffer with consumer stalled
    out_ready = 2'b00; in_valid[1] = 1'b1;
    stim = mk(32'h200, 32'hDEAD, 32'h55, 5'd7, 1'b1, 1'b0, 1'b0); step();
    chk("skid occ1", o1_occ, 1); chk("skid in_ready one", ir1, 1);
    stim = mk(32'h204, 32'hBEEF, 32'h66, 5'd8, 1'b0, 1'b1, 1'b0); step();
    in_valid[1] = 1'b0;
    chk("skid occ2", o1_occ, 2); chk("skid in_ready full", ir1, 0);
    chk("skid head pc", o1_pc, 32'h200);
    step();
    chk("skid hold pc", o1_pc, 32'h200); chk("skid hold alu", o1_alu, 32'hDEAD);
    chk("skid hold dest/wb", {o1_dest, o1_wb}, {5'd7, 1'b1}); chk("skid hold occ", o1_occ, 2);
    out_ready[1] = 1'b1; step();
    chk("skid drain pc", o1_pc, 32'h204); chk("skid drain occ", o1_occ, 1);
    chk("skid in_ready back", ir1, 1); chk("skid drain mr", o1_mr, 1);
    step();
    chk("skid empty valid", o1_valid, 0);

    // Flush while FULL of store entries; input offered during flush is dropped
    out_ready[1] = 1'b0; in_valid[1] = 1'b1;
    stim = mk(32'h300, 32'h1, 32'h1111, 5'd3, 1'b0, 1'b0, 1'b1); step();
    stim = mk(32'h304, 32'h2, 32'h2222, 5'd4, 1'b0, 1'b0, 1'b1); step();
    chk("flush pre occ", o1_occ, 2); chk("flush pre mw", o1_mw, 1);
    flush = 1'b1; out_ready[1] = 1'b1;
    stim = mk(32'h3FC, 32'h3, 32'h3333, 5'd5, 1'b1, 1'b0, 1'b1); #1;
    chk("flush in_ready", ir1, 0);
    step();
    flush = 1'b0; in_valid[1] = 1'b0; #1;
    chk("flush valid", o1_valid, 0); chk("flush mw", o1_mw, 0);
    chk("flush occ", o1_occ, 0); chk("flush in_ready after", ir1, 1);
    chk("flush data held", o1_pc, 32'h300);
    step(); step();
    chk("flush dropped input", o1_valid, 0);

    // SKID=0: combinational in_ready follows out_ready
    out_ready = 2'b00; in_valid[0] = 1'b1;
    stim = mk(32'h400, 32'h4, 32'h44, 5'd9, 1'b1, 1'b0, 1'b0); step();
    chk("s0 occ", o0_occ, 1); chk("s0 pc", o0_pc, 32'h400);
    stim = mk(32'h404, 32'h5, 32'h55, 5'd10, 1'b0, 1'b1, 1'b1); #1;
    chk("s0 in_ready stalled", ir0, 0);
    out_ready[0] = 1'b1; #1;
    chk("s0 in_ready comb", ir0, 1);
    step();
    chk("s0 b2b pc", o0_pc, 32'h404); chk("s0 b2b occ", o0_occ, 1);
    chk("s0 b2b mw", o0_mw, 1);
    in_valid[0] = 1'b0; step();
    chk("s0 empty valid", o0_valid, 0); chk("s0 empty occ", o0_occ, 0);

    // Reset mid-operation with SKID=1 full
    out_ready = 2'b00; in_valid[1] = 1'b1;
    stim = mk(32'h500, 32'h50, 32'h5050, 5'd11, 1'b1, 1'b1, 1'b0); step();
    stim = mk(32'h504, 32'h54, 32'h5454, 5'd12, 1'b0, 1'b0, 1'b1); step();
    in_valid[1] = 1'b0;
    chk("mid-rst pre occ", o1_occ, 2);
    rst = 1'b1; step();
    rst = 1'b0; #1;
    chk("mid-rst occ", o1_occ, 0); chk("mid-rst valid", o1_valid, 0);
    chk("mid-rst pc/alu", {o1_pc, o1_alu}, 64'd0);
    chk("mid-rst st/dest/ctl", {o1_st, o1_dest, o1_wb, o1_mr, o1_mw}, 64'd0);
    chk("mid-rst in_ready", ir1, 1);
    step(); step();

    chk("d1 scoreboard drained", q1.size(), 0);
    chk("d0 scoreboard drained", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
Parametrised EXE→MEM pipeline register for the MIPS pipeline. It carries PC, ALU result, store value, destination register and the WB/MEM control bits. It adds a valid/ready handshake, flush (bubble insertion) and an optional 2-entry skid buffer, so MEM-side stalls do not create a combinational ready path back into EXE. It sits between the EXE stage ALU and the data-memory stage.

Parameters:
DATA_W, 32, width of PC, ALU result and store value fields
DEST_W, 5, width of destination register index
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous kill of all held entries (branch/exception)
in_valid  in  1  EXE presents a valid instruction
in_ready  out  1  register can accept this cycle
in_pc  in  DATA_W  instruction PC
in_alu_result  in  DATA_W  ALU output
in_st_val  in  DATA_W  store data
in_dest  in  DEST_W  writeback register index
in_wb_en  in  1  writeback enable
in_mem_r_en  in  1  memory read enable
in_mem_w_en  in  1  memory write enable
out_valid  out  1  head entry valid
out_ready  in  1  MEM stage consumes head this cycle
out_pc, out_alu_result, out_st_val  out  DATA_W  head entry fields
out_dest  out  DEST_W  head entry destination
out_wb_en, out_mem_r_en, out_mem_w_en  out  1  head control bits; forced 0 when out_valid=0
occupancy  out  2  entries held (0..1 if SKID=0, 0..2 if SKID=1)

Behaviour:
- Accept = in_valid & in_ready; pop = out_valid & out_ready. All state changes happen on the rising edge of clk only.
- Priority: rst > flush > normal operation.
- Reset: all outputs and internal registers 0, including data fields. After reset: out_valid=0, occupancy=0, in_ready=1.
- Flush: every entry is invalidated, stored control bits are cleared, and occupancy becomes 0. Data fields hold their last value. in_ready=0 during the flush cycle, so input presented that cycle is dropped. A pop in the same cycle still counts at the consumer; the stage ignores it.
- Control outputs are stored gated: a bubble never carries wb/mem enables.
- SKID=0:
  - in_ready = ~flush & (out_ready | ~out_valid), combinational.
  - On accept, the head loads the inputs and out_valid=1.
  - On pop without accept, out_valid goes to 0.
  - Accept and pop in the same cycle give back-to-back throughput of 1/cycle.
- SKID=1: two registers, head H and skid S. States are EMPTY (occ 0), ONE (H valid), FULL (H and S valid).
  - in_ready = ~flush & ~S_valid, driven from a register (no path from out_ready).
  - EMPTY + accept → ONE; H loads the input.
  - ONE + accept & pop → ONE; H loads the input.
  - ONE + accept & ~pop → FULL; S loads the input.
  - ONE + pop & ~accept → EMPTY.
  - FULL + pop → ONE; H loads S. Accept is impossible because in_ready=0.
  - FULL + ~pop → FULL; H and S hold.
- Ordering is strictly FIFO. No entry is duplicated or lost except on flush/rst.
- Output fields are stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from accept to out_valid in both modes. Sustained throughput is 1/cycle.
- Reset asserted mid-operation discards all entries identically to the reset case above.
- Assertion for the bench: occupancy never exceeds 1+SKID.

Test Plan:
- Reset with rst=1 for 2 cycles while in_valid=1 → out_valid=0, all out_* = 0, occupancy=0, in_ready=1 the cycle after rst deasserts.
- Stream PC=0x100,0x104,0x108 on consecutive cycles, out_ready=1 → same PCs appear at out_pc on cycles +1, +2, +3; occupancy stays 1; no gaps.
- SKID=1, out_ready=0, send PC 0x200 (alu 0xDEAD, dest 7, wb_en 1) then 0x204 → occupancy=2, in_ready=0, out_pc=0x200 held stable. Raise out_ready → 0x200 then 0x204 delivered in order, in_ready returns to 1.
- SKID=1 in FULL state with mem_w_en=1 entries, assert flush 1 cycle → next cycle out_valid=0, out_mem_w_en=0, occupancy=0. An input offered during flush is not delivered.
- SKID=0, out_ready=0 with one entry held → in_ready=0 combinationally. Toggling out_ready=1 the same cycle gives in_ready=1; accept and pop both occur and occupancy stays 1.
- rst asserted while occupancy=2 → next cycle occupancy=0, all outputs 0.
